pipe_stage_reg: RTL
===================

# pipe_stage_reg

Generic, parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It replaces the fixed-field, enable-driven stage registers between fetch, decode, execute, memory and writeback. Callers pack their stage fields into one `DATA_WIDTH` payload. Back-pressure propagates without a combinational ready path. Flush squashes in-flight work in one cycle.

## Interface
- `DATA_WIDTH`, default 160: width of the packed stage payload.
- `CNT_WIDTH`, default 16: width of each performance counter. Used only with `PIPE_STAGE_PERF_EN`.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `flush`, input, 1: synchronous squash of all held entries.
- `in_valid`, input, 1: upstream has a payload.
- `in_ready`, output, 1: stage can accept a payload.
- `in_data`, input, `DATA_WIDTH`: upstream payload.
- `out_valid`, output, 1: `out_data` holds a live payload.
- `out_ready`, input, 1: downstream accepts this cycle.
- `out_data`, output, `DATA_WIDTH`: payload to the next stage.
- `perf_clr`, input, 1: synchronous clear of both counters. Present only with `PIPE_STAGE_PERF_EN`.
- `stall_cnt`, output, `CNT_WIDTH`: count of back-pressured cycles. Present only with `PIPE_STAGE_PERF_EN`.
- `bubble_cnt`, output, `CNT_WIDTH`: count of empty-output cycles. Present only with `PIPE_STAGE_PERF_EN`.

## Operation
- `in_fire = in_valid & in_ready`.
- `out_fire = out_valid & out_ready`.
- Storage: `main` register (drives `out_data`) and `skid` register. State `st` ∈ {EMPTY, ONE, FULL}.
- `out_valid = (st != EMPTY)`.
- `in_ready = (st != FULL)`. It is a function of state only, never of `out_ready` or `in_valid`.
- EMPTY:
  - `in_fire` → `main<=in_data`, go to ONE.
- ONE:
  - `in_fire & out_fire` → `main<=in_data`, stay in ONE.
  - `in_fire & !out_fire` → `skid<=in_data`, go to FULL.
  - `!in_fire & out_fire` → go to EMPTY.
  - Otherwise hold.
- FULL:
  - `out_fire` → `main<=skid`, go to ONE. No input is accepted in FULL.
  - Otherwise hold.
- `flush` has priority over everything:
  - Next state is EMPTY.
  - Any `in_fire` in the same cycle is discarded.
  - `main` and `skid` are written to 0.
  - An `out_fire` in the flush cycle still counts as a completed transfer for the downstream stage.
- Order is strictly FIFO. No payload is duplicated or dropped except by flush.
- `out_data` is stable while `out_valid & !out_ready`.
- Reset values: `st`=EMPTY, `main`=0, `skid`=0, `out_valid`=0, `out_data`=0, `in_ready`=1, `stall_cnt`=0, `bubble_cnt`=0.

## Timing
- Latency: an `in_fire` at edge N makes `out_valid`=1 with that payload after edge N, i.e. one cycle.
- Throughput: one payload per cycle while `out_ready`=1.
- `in_ready` falls exactly one cycle after the first non-accepted output with a new input. It rises in the cycle after the FULL→ONE drain.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Held payloads are lost.
- On `rst` deassertion the first accept is possible at the next edge.
- Flush recovery: after a flush edge the stage is EMPTY with `in_ready`=1. A new `in_fire` is possible at the very next edge.

## Configuration
- Macro `PIPE_STAGE_PERF_EN`.
- Defined:
  - `stall_cnt` increments each cycle with `out_valid & !out_ready`.
  - `bubble_cnt` increments each cycle with `!out_valid`.
  - Both counters saturate at all-ones and are not cleared by flush.
  - `perf_clr` zeroes both counters and has priority over increment.
- Undefined: counters, `perf_clr`, `stall_cnt` and `bubble_cnt` ports are absent. Handshake behaviour is identical.

## Test plan
- Streaming: `out_ready`=1, feed 0x1..0x8 on consecutive cycles → `out_data` 0x1..0x8 on consecutive cycles, each one cycle late. `in_ready` stays 1.
- Back-pressure: feed 0xA, 0xB, 0xC with `out_ready`=0 → 0xA, 0xB accepted, `in_ready`=0 and 0xC held upstream. Release `out_ready` → output is 0xA, 0xB, 0xC in order with no loss.
- Flush in FULL with a simultaneous `in_valid` of 0xD → next cycle `out_valid`=0 and `in_ready`=1, 0xD never appears. The next input 0xE appears one cycle after its accept.
- Async reset asserted between edges while FULL → `out_valid`, `out_data` and the state go to 0/EMPTY immediately and `in_ready`=1.
- Perf (with `PIPE_STAGE_PERF_EN`, `CNT_WIDTH`=4): 20 stalled cycles → `stall_cnt`=0xF (saturated). `perf_clr` → 0. Three idle cycles → `bubble_cnt`=3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//
// Generic pipeline stage register. It uses a valid/ready handshake and a
// two-entry skid buffer. Upstream stages pack their fields into one
// DATA_WIDTH payload.
//
// in_ready depends only on the registered state, so no combinational path
// runs from out_ready back to in_ready. flush squashes everything held in a
// single cycle.
//
// Parameters
//   DATA_WIDTH  width of the packed stage payload (default 160)
//   CNT_WIDTH   width of each performance counter (default 16).
//               Only used when PIPE_STAGE_PERF_EN is defined.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   flush       synchronous squash of all held entries
//   in_valid    upstream offers in_data
//   in_ready    stage can accept a payload (state-only)
//   in_data     upstream payload
//   out_valid   out_data holds a live payload
//   out_ready   downstream accepts this cycle
//   out_data    payload to the next stage
//   perf_clr    synchronous clear of both counters   (PIPE_STAGE_PERF_EN)
//   stall_cnt   saturating count of back-pressured cycles (PIPE_STAGE_PERF_EN)
//   bubble_cnt  saturating count of empty-output cycles   (PIPE_STAGE_PERF_EN)
//
// Optional feature macro: PIPE_STAGE_PERF_EN (adds perf counters and their ports).

module pipe_stage_reg #(
  parameter int DATA_WIDTH = 160,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  bubble_cnt
`endif
);

  // Reject nonsensical configurations at elaboration time.
  if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("pipe_stage_reg: DATA_WIDTH and CNT_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } st_t;

  st_t st_p0, st_nxt;

  // main_p0 always holds the oldest payload. skid_p0 holds the one behind it.
  logic [DATA_WIDTH-1:0] main_p0;
  logic [DATA_WIDTH-1:0] skid_p0;

  logic in_fire;
  logic out_fire;
  logic load_main;
  logic main_from_skid;
  logic load_skid;

  assign in_ready  = (st_p0 != FULL);
  assign out_valid = (st_p0 != EMPTY);
  assign out_data  = main_p0;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // ---- stage control: next state and register load enables ----
  always_comb begin
    st_nxt         = st_p0;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      unique case (st_p0)
        EMPTY: begin
          if (in_fire) begin
            load_main = 1'b1;
            st_nxt    = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            st_nxt    = FULL;
          end else if (out_fire) begin
            st_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path can move.
          if (out_fire) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            st_nxt         = ONE;
          end
        end
        default: st_nxt = EMPTY;
      endcase
    end else begin
      st_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_p0 <= EMPTY;
    end else begin
      st_p0 <= st_nxt;
    end
  end

  // ---- stage data: main/skid payload registers ----
  // The payload registers are cleared on reset and on flush, so a squashed
  // payload never lingers on out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_p0 <= '0;
      skid_p0 <= '0;
    end else if (flush) begin
      main_p0 <= '0;
      skid_p0 <= '0;
    end else begin
      if (load_main) begin
        main_p0 <= main_from_skid ? skid_p0 : in_data;
      end
      if (load_skid) begin
        skid_p0 <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ---- perf counters: saturating, cleared only by reset/perf_clr ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (!out_valid) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
    end
  end
`endif

endmodule
